// File: rtl/cgra_port_arbiter.sv
// cgra_port_arbiter: 5-way round-robin arbiter feeding a single registered
// output flit slot for a CGRA router port (N, E, S, W, Local).
// Optional feature macro: CGRA_ARB_GRANT_CNT_EN adds a 16-bit transfer counter
// output (grant_cnt) that wraps from 0xFFFF to 0.
module cgra_port_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REQ    = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_dest_x,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_dest_y,
  input  logic [NUM_REQ-1:0]            req_multicast,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [ADDR_WIDTH-1:0]         out_dest_x,
  output logic [ADDR_WIDTH-1:0]         out_dest_y,
  output logic                          out_multicast,
  input  logic                          out_ready,
  output logic [2:0]                    grant_idx
`ifdef CGRA_ARB_GRANT_CNT_EN
  ,
  output logic [15:0]                   grant_cnt
`endif
);

  // Unpacked per-requester views of the flattened payload buses
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [ADDR_WIDTH-1:0] dx_arr   [NUM_REQ];
  logic [ADDR_WIDTH-1:0] dy_arr   [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign dx_arr[gi]   = req_dest_x[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign dy_arr[gi]   = req_dest_y[gi*ADDR_WIDTH +: ADDR_WIDTH];
    end
  endgenerate

  logic [2:0]            rr_ptr_q, rr_ptr_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ADDR_WIDTH-1:0] out_dx_q, out_dx_d;
  logic [ADDR_WIDTH-1:0] out_dy_q, out_dy_d;
  logic                  out_mc_q, out_mc_d;
  logic [2:0]            grant_q, grant_d;

  logic       load_en;
  logic       win_found;
  logic [2:0] win_idx;
  logic [3:0] cand;
  logic       xfer;

  // The output slot can take a new flit when empty or being drained this cycle
  assign load_en = !out_valid_q || out_ready;

  // Winner search: first valid requester starting at rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + 4'(k);
      if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
      if (!win_found && req_valid[cand[2:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[2:0];
      end
    end
  end

  // One-hot accept to the winner; held at zero during reset and backpressure
  always_comb begin
    req_ready = '0;
    if (!rst && load_en && win_found) req_ready[win_idx] = 1'b1;
  end

  assign xfer = |req_ready;

  // Next-state for the output flit register and round-robin pointer
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_dx_d    = out_dx_q;
    out_dy_d    = out_dy_q;
    out_mc_d    = out_mc_q;
    grant_d     = grant_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = data_arr[win_idx];
      out_dx_d    = dx_arr[win_idx];
      out_dy_d    = dy_arr[win_idx];
      out_mc_d    = req_multicast[win_idx];
      grant_d     = win_idx;
      rr_ptr_d    = (win_idx == 3'(NUM_REQ - 1)) ? 3'd0 : win_idx + 3'd1;
    end else if (out_ready) begin
      // Drained with nothing to replace it: payload keeps its last value
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset discards any flit held in the output slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_dx_q    <= '0;
      out_dy_q    <= '0;
      out_mc_q    <= 1'b0;
      grant_q     <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_dx_q    <= out_dx_d;
      out_dy_q    <= out_dy_d;
      out_mc_q    <= out_mc_d;
      grant_q     <= grant_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_dest_x    = out_dx_q;
  assign out_dest_y    = out_dy_q;
  assign out_multicast = out_mc_q;
  assign grant_idx     = grant_q;

`ifdef CGRA_ARB_GRANT_CNT_EN
  logic [15:0] grant_cnt_q;

  // Transfer counter, naturally wraps at 16 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) grant_cnt_q <= '0;
    else if (xfer) grant_cnt_q <= grant_cnt_q + 16'd1;
  end

  assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_cgra_port_arbiter.sv
// Randomized + directed bench for cgra_port_arbiter with a scoreboard.
// Build with CGRA_ARB_GRANT_CNT_EN defined to also check grant_cnt.
module tb_cgra_port_arbiter;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NR = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR*AW-1:0]  req_dest_x;
  logic [NR*AW-1:0]  req_dest_y;
  logic [NR-1:0]     req_multicast;
  logic [NR-1:0]     req_ready;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic [AW-1:0]     out_dest_x;
  logic [AW-1:0]     out_dest_y;
  logic              out_multicast;
  logic              out_ready;
  logic [2:0]        grant_idx;
`ifdef CGRA_ARB_GRANT_CNT_EN
  logic [15:0]       grant_cnt;
`endif

  cgra_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data),
    .req_dest_x(req_dest_x), .req_dest_y(req_dest_y),
    .req_multicast(req_multicast), .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data),
    .out_dest_x(out_dest_x), .out_dest_y(out_dest_y),
    .out_multicast(out_multicast), .out_ready(out_ready),
    .grant_idx(grant_idx)
`ifdef CGRA_ARB_GRANT_CNT_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [AW-1:0] x;
    logic [AW-1:0] y;
    logic          mc;
    logic [2:0]    g;
  } flit_t;

  flit_t sb_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state: round-robin position, slot occupancy, transfer count
  int m_rr  = 0;
  bit m_ov  = 0;
  int m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // One clock of stimulus: drive inputs, predict accept, check, update model
  task automatic drive(input logic [NR-1:0] v, input logic ordy, input bit rnd);
    int w;
    logic [NR-1:0] exp_ready;
    flit_t f;
    req_valid = v;
    out_ready = ordy;
    if (rnd) begin
      for (int i = 0; i < NR; i++) begin
        req_data[i*DW +: DW]   = DW'($urandom);
        req_dest_x[i*AW +: AW] = AW'($urandom_range(0, 15));
        req_dest_y[i*AW +: AW] = AW'($urandom_range(0, 15));
        req_multicast[i]       = 1'($urandom_range(0, 1));
      end
    end
    w = -1;
    exp_ready = '0;
    if (!m_ov || ordy) begin
      for (int k = 0; k < NR; k++) begin
        int i;
        i = (m_rr + k) % NR;
        if (w < 0 && v[i]) w = i;
      end
    end
    if (w >= 0) exp_ready[w] = 1'b1;
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
`ifdef CGRA_ARB_GRANT_CNT_EN
    chk("grant_cnt", 32'(grant_cnt), 32'(m_cnt % 65536));
`endif
    @(posedge clk);
    if (w >= 0) begin
      f.d  = req_data[w*DW +: DW];
      f.x  = req_dest_x[w*AW +: AW];
      f.y  = req_dest_y[w*AW +: AW];
      f.mc = req_multicast[w];
      f.g  = 3'(w);
      sb_q.push_back(f);
      m_rr = (w + 1) % NR;
      m_ov = 1'b1;
      m_cnt++;
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    $display("cyc v=%b ordy=%b grant=%0d", v, ordy, w);
    #1;
  endtask

  // Monitor: presented flit must match the scoreboard head; pop on handshake
  always @(negedge clk) begin
    flit_t got_f;
    if (!rst && out_valid) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL mon_flit got unexpected flit %h want none", out_data);
      end else begin
        got_f = '{d: out_data, x: out_dest_x, y: out_dest_y, mc: out_multicast, g: grant_idx};
        if (got_f !== sb_q[0]) begin
          errors++;
          $display("FAIL mon_flit got %h want %h", got_f, sb_q[0]);
        end
        if (out_ready) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    req_valid = '1;
    req_data = '0; req_dest_x = '0; req_dest_y = '0; req_multicast = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_grant_idx", 32'(grant_idx), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    req_valid = '0;

    // Single Local flit
    req_data[4*DW +: DW] = 16'hABCD;
    req_dest_x[4*AW +: AW] = 4'd3;
    req_dest_y[4*AW +: AW] = 4'd1;
    req_multicast[4] = 1'b0;
    drive(5'b10000, 1'b1, 0);
    chk("single_data", 32'(out_data), 32'hABCD);
    chk("single_dx", 32'(out_dest_x), 32'd3);
    chk("single_dy", 32'(out_dest_y), 32'd1);
    chk("single_grant", 32'(grant_idx), 32'd4);
    chk("single_valid", 32'(out_valid), 32'd1);

    // Fairness: all valid, grants rotate 0..4 twice
    for (int c = 0; c < 10; c++) begin
      drive(5'b11111, 1'b1, 1);
      chk("fair_grant", 32'(grant_idx), 32'(c % NR));
    end

    // Backpressure: N flit held while E waits
    req_data[0 +: DW] = 16'h1234;
    drive(5'b00001, 1'b1, 0);
    req_data[1*DW +: DW] = 16'h9A9A;
    for (int c = 0; c < 3; c++) begin
      drive(5'b00010, 1'b0, 0);
      chk("bp_hold_data", 32'(out_data), 32'h1234);
    end
    drive(5'b00010, 1'b1, 0);
    chk("bp_release_data", 32'(out_data), 32'h9A9A);
    chk("bp_release_grant", 32'(grant_idx), 32'd1);

    // Skip and wrap: pointer at 4, only E valid
    drive(5'b01000, 1'b1, 1);
    req_data[1*DW +: DW] = 16'h5678;
    drive(5'b00010, 1'b1, 0);
    chk("wrap_grant", 32'(grant_idx), 32'd1);
    chk("wrap_data", 32'(out_data), 32'h5678);
    drive(5'b00110, 1'b1, 1);
    chk("wrap_next_ptr", 32'(grant_idx), 32'd2);

    // Asynchronous reset with a multicast flit held in the slot
    req_data[0 +: DW] = 16'hFFFF;
    req_multicast[0] = 1'b1;
    drive(5'b00001, 1'b1, 0);
    chk("pre_rst_data", 32'(out_data), 32'hFFFF);
    out_ready = 1'b0;
    req_valid = 5'b11111;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_mc", 32'(out_multicast), 32'd0);
    chk("async_rst_ready", 32'(req_ready), 32'd0);
    sb_q.delete();
    m_ov = 0; m_rr = 0; m_cnt = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    drive(5'b11010, 1'b1, 1);
    chk("post_rst_grant", 32'(grant_idx), 32'd1);

    // Randomized traffic with random backpressure
    for (int c = 0; c < 300; c++)
      drive(5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0), 1);
    drive(5'b00000, 1'b1, 1);
    drive(5'b00000, 1'b1, 1);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cgra_port_arbiter.md
CGRA_PORT_ARBITER -- requirements
Module: cgra_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, payload width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, dest coordinate width.
REQ-003 SHALL have parameter NUM_REQ, fixed 5, requesters: index 0=N, 1=E, 2=S, 3=W, 4=Local.
REQ-004 SHALL have port clk, input, 1, single clock; all logic rising-edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port req_valid, input, 5, per-requester flit valid.
REQ-007 SHALL have port req_data, input, 5*DATA_WIDTH, payloads; requester i at slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have ports req_dest_x and req_dest_y, input, 5*ADDR_WIDTH each, packed the same way.
REQ-009 SHALL have port req_multicast, input, 5, per-requester multicast flag.
REQ-010 SHALL have port req_ready, output, 5, one-hot-or-zero accept to requesters.
REQ-011 SHALL have ports out_valid (1), out_data (DATA_WIDTH), out_dest_x and out_dest_y (ADDR_WIDTH each), out_multicast (1), all outputs: the registered output flit.
REQ-012 SHALL have port out_ready, input, 1, downstream accept.
REQ-013 SHALL have port grant_idx, output, 3, index of the requester whose flit occupies the output register.

Function
REQ-014 SHALL define load_en = !out_valid || out_ready, combinationally.
REQ-015 SHALL select the winner as the first requester with req_valid set, scanning from rr_ptr upward modulo 5.
REQ-016 SHALL assert req_ready[winner] only when load_en=1 and a winner exists; all other bits SHALL be 0; req_ready SHALL NOT depend on req_data.
REQ-017 A transfer occurs when req_valid[i] and req_ready[i] are both 1; on that edge the winner's data, dest_x, dest_y and multicast SHALL load into the output register, out_valid SHALL become 1, and grant_idx SHALL become the winner index.
REQ-018 Latency SHALL be 1 cycle from the accepting edge to out_valid.
REQ-019 On a transfer, rr_ptr SHALL become (winner+1) mod 5: index 4 wraps to 0. With no transfer, rr_ptr SHALL hold.
REQ-020 When out_valid=1 and out_ready=0, all out_* signals and grant_idx SHALL hold stable and req_ready SHALL be all zero (backpressure).
REQ-021 When out_valid=1, out_ready=1 and any requester is valid, a new flit SHALL load on the same edge (full throughput, no bubble).
REQ-022 When out_ready=1 and no requester is valid, out_valid SHALL clear on the next edge; out_data and the other payload outputs SHALL hold their last value.
REQ-023 With all 5 requesters continuously valid and out_ready=1, grants SHALL rotate 0,1,2,3,4,0..., one per cycle; no requester SHALL wait more than 4 grants.
REQ-024 A requester SHALL NOT be granted while its req_valid is 0, even when it is the rr_ptr position.

Reset
REQ-025 While rst=1, out_valid SHALL be 0, out_data, out_dest_x, out_dest_y, out_multicast and grant_idx SHALL be 0, and rr_ptr SHALL be 0, regardless of clk.
REQ-026 req_ready SHALL be all zero while rst=1.
REQ-027 A flit held in the output register when rst asserts SHALL be discarded; after rst deasserts, the first grant SHALL go to the lowest valid index.

Configuration
REQ-028 With macro CGRA_ARB_GRANT_CNT_EN defined, there SHALL be an extra output port grant_cnt, 16 bits, counting transfers; it SHALL reset to 0, wrap from 0xFFFF to 0, and increment by exactly 1 per transfer.
REQ-029 Without CGRA_ARB_GRANT_CNT_EN, the grant_cnt port and counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Single flit: after reset, req_valid=5'b10000 (Local), data 16'hABCD, dest (3,1), out_ready=1 -> next cycle out_valid=1, out_data=ABCD, out_dest_x=3, out_dest_y=1, grant_idx=4.
REQ-031 Fairness: all 5 requesters valid for 10 cycles, out_ready=1 -> grant_idx sequence 0,1,2,3,4,0,1,2,3,4, one flit per cycle.
REQ-032 Backpressure: output holds 16'h1234 from N, out_ready=0 for 3 cycles while E is valid -> out_data stays 1234 and req_ready=0 for those 3 cycles; with out_ready=1, E's flit appears next cycle.
REQ-033 Skip and wrap: rr_ptr=4 and only req_valid[1] set with 16'h5678 -> grant_idx=1, and the next pointer is 2.
REQ-034 Reset mid-operation: assert rst asynchronously while out_valid=1 holding 16'hFFFF with multicast=1 -> out_valid=0 and out_multicast=0 immediately, before the next clock edge; after release, the lowest valid index wins.
REQ-035 With CGRA_ARB_GRANT_CNT_EN defined, 7 transfers -> grant_cnt=7; with the counter preset to 0xFFFF and one more transfer -> grant_cnt=0.
